// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter-chain control outputs of the stopwatch controller.
// The controller takes the slave side; whatever drives the buttons takes the master side.
interface stopwatch_ctrl_if;
    logic       BTN_START;
    logic       BTN_CLEAR;
    logic       BTN_LAP;
    logic       CNT_EN;
    logic       CNT_CLR;
    logic       LAP_HOLD;
    logic [1:0] STATE;

    modport master (
        output BTN_START, BTN_CLEAR, BTN_LAP,
        input  CNT_EN, CNT_CLR, LAP_HOLD, STATE
    );

    modport slave (
        input  BTN_START, BTN_CLEAR, BTN_LAP,
        output CNT_EN, CNT_CLR, LAP_HOLD, STATE
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounces three pushbuttons, runs the IDLE/RUN/PAUSE FSM and
// divides the clock down to a 1 Hz advance pulse for the external counter chain.
module stopwatch_ctrl #(
    parameter int SEC1_MAX   = 12000000,
    parameter int DEB_CYCLES = 120000
) (
    input logic             CLK,
    input logic             RESET,
    stopwatch_ctrl_if.slave bus
);
    localparam int PRE_W = (SEC1_MAX > 1) ? $clog2(SEC1_MAX) : 1;
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SEC1_MAX - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    logic [2:0]            rawBtn;
    logic [2:0]            syncMetaQ;
    logic [2:0]            syncQ;
    logic [2:0]            accQ;
    logic [2:0]            accD;
    logic [2:0]            accPrevQ;
    logic [2:0]            pressEv;
    logic [2:0][DEB_W-1:0] cntQ;
    logic [2:0][DEB_W-1:0] cntD;

    state_t                stateQ;
    logic [PRE_W-1:0]      preQ;
    logic [PRE_W-1:0]      preD;
    logic                  lapHoldQ;
    logic                  cntClrQ;
    logic                  startEv;
    logic                  clearEv;
    logic                  lapEv;

    assign rawBtn = {bus.BTN_LAP, bus.BTN_CLEAR, bus.BTN_START};

    // The stability count only advances while the synchronized level disagrees with
    // the accepted one; the accepted level flips on the DEB_CYCLES-th such sample.
    always_comb begin
        accD = accQ;
        cntD = '0;
        for (int i = 0; i < 3; i++) begin
            if (syncQ[i] != accQ[i]) begin
                if (cntQ[i] == DEB_LAST) begin
                    accD[i] = syncQ[i];
                end else begin
                    cntD[i] = cntQ[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            syncMetaQ <= '0;
            syncQ     <= '0;
            accQ      <= '0;
            accPrevQ  <= '0;
            cntQ      <= '0;
        end else begin
            syncMetaQ <= rawBtn;
            syncQ     <= syncMetaQ;
            accQ      <= accD;
            accPrevQ  <= accQ;
            cntQ      <= cntD;
        end
    end

    assign pressEv = accQ & ~accPrevQ;
    assign startEv = pressEv[0];
    assign clearEv = pressEv[1];
    assign lapEv   = pressEv[2];

    // Leaving RUN still advances the prescaler that cycle, so a stop on the last
    // count keeps its pulse and the phase resumes from zero.
    always_comb begin
        preD = '0;
        case (stateQ)
            RUN:     preD = (preQ == PRE_LAST) ? '0 : preQ + 1'b1;
            PAUSE:   preD = clearEv ? '0 : preQ;
            default: preD = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stateQ   <= IDLE;
            preQ     <= '0;
            lapHoldQ <= 1'b0;
            cntClrQ  <= 1'b0;
        end else begin
            preQ    <= preD;
            cntClrQ <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (clearEv) begin
                        cntClrQ <= 1'b1;
                    end else if (startEv) begin
                        stateQ <= RUN;
                    end
                end
                RUN: begin
                    if (startEv) begin
                        stateQ <= PAUSE;
                    end else if (lapEv) begin
                        lapHoldQ <= ~lapHoldQ;
                    end
                end
                PAUSE: begin
                    if (clearEv) begin
                        stateQ   <= IDLE;
                        cntClrQ  <= 1'b1;
                        lapHoldQ <= 1'b0;
                    end else if (startEv) begin
                        stateQ <= RUN;
                    end else if (lapEv) begin
                        lapHoldQ <= 1'b0;
                    end
                end
                default: begin
                    stateQ   <= IDLE;
                    lapHoldQ <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CNT_EN   = (stateQ == RUN) && (preQ == PRE_LAST);
    assign bus.CNT_CLR  = cntClrQ;
    assign bus.LAP_HOLD = lapHoldQ;
    assign bus.STATE    = stateQ;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, targeted timing sequences and random button
// activity, all checked against a cycle-level behavioural model of the stopwatch.
module tb_stopwatch_ctrl;
    localparam int SEC1_MAX   = 10;
    localparam int DEB_CYCLES = 4;
    localparam int NBTN       = 3;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    stopwatch_ctrl_if swIf ();

    stopwatch_ctrl #(
        .SEC1_MAX  (SEC1_MAX),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (swIf)
    );

    always #5 CLK = ~CLK;

    int errors  = 0;
    int checks  = 0;
    bit checkEn = 1'b0;

    typedef struct {
        bit         btnStart;
        bit         btnClear;
        bit         btnLap;
        logic [1:0] expState;
        bit         expLap;
    } vec_t;

    vec_t vecs[15];

    // Model: mState 0 idle / 1 running / 2 paused; the sub-second phase is the number
    // of running cycles since the last clear, modulo SEC1_MAX.
    int mState;
    bit mLap;
    bit mClr;
    int runCycles;
    bit mAcc[NBTN];
    bit mPress[NBTN];
    bit rawHist[NBTN][$];

    function automatic bit rawOf(input int b);
        case (b)
            0:       return swIf.BTN_START;
            1:       return swIf.BTN_CLEAR;
            default: return swIf.BTN_LAP;
        endcase
    endfunction

    function automatic void modelReset();
        mState    = 0;
        mLap      = 1'b0;
        mClr      = 1'b0;
        runCycles = 0;
        for (int b = 0; b < NBTN; b++) begin
            mAcc[b]   = 1'b0;
            mPress[b] = 1'b0;
            rawHist[b].delete();
            for (int j = 0; j < DEB_CYCLES + 2; j++) rawHist[b].push_back(1'b0);
        end
    endfunction

    // A button's level is accepted once the last DEB_CYCLES samples, each seen two
    // edges late, all disagree with it; presses act one edge after acceptance.
    function automatic void modelStep();
        bit evS, evC, evL, allDiff, newAcc;
        int n;
        evS  = mPress[0];
        evC  = mPress[1];
        evL  = mPress[2];
        mClr = 1'b0;
        if (mState == 1) runCycles++;
        case (mState)
            0: begin
                if (evC) mClr = 1'b1;
                else if (evS) mState = 1;
            end
            1: begin
                if (evS) mState = 2;
                else if (evL) mLap = !mLap;
            end
            default: begin
                if (evC) begin
                    mState    = 0;
                    mClr      = 1'b1;
                    mLap      = 1'b0;
                    runCycles = 0;
                end else if (evS) begin
                    mState = 1;
                end else if (evL) begin
                    mLap = 1'b0;
                end
            end
        endcase
        for (int b = 0; b < NBTN; b++) begin
            rawHist[b].push_back(rawOf(b));
            if (rawHist[b].size() > 16) void'(rawHist[b].pop_front());
            n = rawHist[b].size();
            allDiff = 1'b1;
            for (int j = 0; j < DEB_CYCLES; j++) begin
                if (rawHist[b][n-3-j] == mAcc[b]) allDiff = 1'b0;
            end
            newAcc    = allDiff ? !mAcc[b] : mAcc[b];
            mPress[b] = newAcc && !mAcc[b];
            mAcc[b]   = newAcc;
        end
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) modelReset();
        else modelStep();
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    always @(negedge CLK) begin
        if (checkEn && !RESET) begin
            checkOutput("model STATE", 32'(swIf.STATE), 32'(mState));
            checkOutput("model LAP_HOLD", 32'(swIf.LAP_HOLD), 32'(mLap));
            checkOutput("model CNT_CLR", 32'(swIf.CNT_CLR), 32'(mClr));
            checkOutput("model CNT_EN", 32'(swIf.CNT_EN),
                        32'((mState == 1) && ((runCycles % SEC1_MAX) == SEC1_MAX - 1)));
        end
    end

    task automatic applyStimulus(input bit s, input bit c, input bit l, input int cycles);
        swIf.BTN_START = s;
        swIf.BTN_CLEAR = c;
        swIf.BTN_LAP   = l;
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic doReset(input bit holdStart);
        RESET          = 1'b1;
        swIf.BTN_START = holdStart;
        swIf.BTN_CLEAR = 1'b0;
        swIf.BTN_LAP   = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic measureStartLatency(input string name);
        int lat;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (swIf.STATE == 2'b01) begin
                lat = i;
                break;
            end
        end
        checkOutput(name, 32'(lat), 32'd7);
    endtask

    task automatic waitCntEn(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (swIf.CNT_EN) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        checkOutput(name, 32'(found), 32'd1);
    endtask

    initial begin
        int enPos[$];
        int k, runEntries, clrPulses, runSeen, lapEdges, badGaps;
        bit sawLap, prevLap;
        logic [1:0] prevState;

        vecs[0]  = '{1, 0, 0, 2'b01, 0};
        vecs[1]  = '{0, 0, 1, 2'b01, 1};
        vecs[2]  = '{0, 0, 1, 2'b01, 0};
        vecs[3]  = '{0, 0, 1, 2'b01, 1};
        vecs[4]  = '{1, 0, 0, 2'b10, 1};
        vecs[5]  = '{0, 0, 1, 2'b10, 0};
        vecs[6]  = '{1, 0, 0, 2'b01, 0};
        vecs[7]  = '{0, 1, 0, 2'b01, 0};
        vecs[8]  = '{1, 0, 0, 2'b10, 0};
        vecs[9]  = '{0, 1, 0, 2'b00, 0};
        vecs[10] = '{0, 0, 1, 2'b00, 0};
        vecs[11] = '{0, 1, 0, 2'b00, 0};
        vecs[12] = '{1, 0, 1, 2'b01, 0};
        vecs[13] = '{1, 0, 1, 2'b10, 0};
        vecs[14] = '{0, 1, 1, 2'b00, 0};

        swIf.BTN_START = 1'b0;
        swIf.BTN_CLEAR = 1'b0;
        swIf.BTN_LAP   = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("reset STATE", 32'(swIf.STATE), 32'd0);
        checkOutput("reset CNT_EN", 32'(swIf.CNT_EN), 32'd0);
        checkOutput("reset CNT_CLR", 32'(swIf.CNT_CLR), 32'd0);
        checkOutput("reset LAP_HOLD", 32'(swIf.LAP_HOLD), 32'd0);
        RESET   = 1'b0;
        checkEn = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].btnStart, vecs[i].btnClear, vecs[i].btnLap, 8);
            applyStimulus(0, 0, 0, 8);
            checkOutput($sformatf("vec%0d STATE", i), 32'(swIf.STATE), 32'(vecs[i].expState));
            checkOutput($sformatf("vec%0d LAP_HOLD", i), 32'(swIf.LAP_HOLD), 32'(vecs[i].expLap));
        end

        // Press-to-RUN latency and the 1 Hz cadence that follows.
        doReset(0);
        swIf.BTN_START = 1'b1;
        measureStartLatency("start latency");
        enPos.delete();
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (i == 3) swIf.BTN_START = 1'b0;
            if (swIf.CNT_EN) enPos.push_back(i);
        end
        checkOutput("CNT_EN pulse count", 32'(enPos.size()), 32'd4);
        if (enPos.size() >= 2) begin
            checkOutput("first CNT_EN offset", 32'(enPos[0]), 32'd9);
            checkOutput("CNT_EN gap", 32'(enPos[1] - enPos[0]), 32'd10);
        end

        // Bouncing start button yields a single transition.
        doReset(0);
        prevState  = 2'b00;
        runEntries = 0;
        for (int i = 0; i < 4; i++) begin
            swIf.BTN_START = (i % 2 == 0);
            @(negedge CLK);
        end
        swIf.BTN_START = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (swIf.STATE == 2'b01 && prevState != 2'b01) runEntries++;
            prevState = swIf.STATE;
        end
        checkOutput("bounce RUN entries", 32'(runEntries), 32'd1);
        checkOutput("bounce final STATE", 32'(swIf.STATE), 32'd1);
        applyStimulus(0, 0, 0, 8);

        // Stop at prescaler 6, resume later: three running cycles to the next pulse.
        doReset(0);
        applyStimulus(1, 0, 0, 8);
        applyStimulus(0, 0, 0, 8);
        waitCntEn("pre-stop CNT_EN seen");
        @(negedge CLK);
        applyStimulus(1, 0, 0, 8);
        applyStimulus(0, 0, 0, 50);
        checkOutput("paused STATE", 32'(swIf.STATE), 32'd2);
        swIf.BTN_START = 1'b1;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (swIf.STATE == 2'b01) k++;
            if (swIf.CNT_EN) break;
        end
        checkOutput("run cycles to CNT_EN after resume", 32'(k), 32'd3);
        applyStimulus(0, 0, 0, 8);

        // Start and clear together while paused.
        doReset(0);
        applyStimulus(1, 0, 0, 8);
        applyStimulus(0, 0, 0, 8);
        applyStimulus(0, 0, 1, 8);
        applyStimulus(0, 0, 0, 8);
        applyStimulus(1, 0, 0, 8);
        applyStimulus(0, 0, 0, 8);
        checkOutput("LAP_HOLD before clear", 32'(swIf.LAP_HOLD), 32'd1);
        swIf.BTN_START = 1'b1;
        swIf.BTN_CLEAR = 1'b1;
        clrPulses = 0;
        runSeen   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (swIf.CNT_CLR) clrPulses++;
            if (swIf.STATE == 2'b01) runSeen++;
        end
        checkOutput("start+clear CNT_CLR pulses", 32'(clrPulses), 32'd1);
        checkOutput("start+clear RUN cycles", 32'(runSeen), 32'd0);
        checkOutput("start+clear STATE", 32'(swIf.STATE), 32'd0);
        checkOutput("start+clear LAP_HOLD", 32'(swIf.LAP_HOLD), 32'd0);
        applyStimulus(0, 0, 0, 8);

        // Two lap presses while running; the pulse cadence must not move.
        doReset(0);
        applyStimulus(1, 0, 0, 8);
        applyStimulus(0, 0, 0, 8);
        enPos.delete();
        lapEdges = 0;
        sawLap   = 1'b0;
        prevLap  = 1'b0;
        for (int i = 0; i < 70; i++) begin
            swIf.BTN_LAP = ((i >= 2 && i < 10) || (i >= 35 && i < 43));
            @(negedge CLK);
            if (swIf.CNT_EN) enPos.push_back(i);
            if (swIf.LAP_HOLD != prevLap) lapEdges++;
            if (swIf.LAP_HOLD) sawLap = 1'b1;
            prevLap = swIf.LAP_HOLD;
        end
        badGaps = 0;
        for (int i = 1; i < enPos.size(); i++) begin
            if (enPos[i] - enPos[i-1] != SEC1_MAX) badGaps++;
        end
        checkOutput("lap LAP_HOLD edges", 32'(lapEdges), 32'd2);
        checkOutput("lap LAP_HOLD went high", 32'(sawLap), 32'd1);
        checkOutput("lap final LAP_HOLD", 32'(swIf.LAP_HOLD), 32'd0);
        checkOutput("lap CNT_EN off-cadence gaps", 32'(badGaps), 32'd0);
        checkOutput("lap CNT_EN at least 6 pulses", 32'(enPos.size() >= 6), 32'd1);

        // Asynchronous reset while CNT_EN is high.
        waitCntEn("CNT_EN before async reset");
        #2 RESET = 1'b1;
        #1;
        checkOutput("async reset STATE", 32'(swIf.STATE), 32'd0);
        checkOutput("async reset CNT_EN", 32'(swIf.CNT_EN), 32'd0);
        checkOutput("async reset CNT_CLR", 32'(swIf.CNT_CLR), 32'd0);
        checkOutput("async reset LAP_HOLD", 32'(swIf.LAP_HOLD), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        checkOutput("post-reset CNT_EN", 32'(swIf.CNT_EN), 32'd0);
        checkOutput("post-reset STATE", 32'(swIf.STATE), 32'd0);

        // Start held through reset counts as a fresh press.
        doReset(1);
        measureStartLatency("held-through-reset latency");
        applyStimulus(0, 0, 0, 8);

        // Random button activity with occasional resets.
        repeat (200) begin
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(1, 12));
            if ($urandom_range(0, 60) == 0) doReset($urandom_range(0, 1) == 1);
        end
        applyStimulus(0, 0, 0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter SEC1_MAX, default 12000000, meaning: CLK cycles per 1 s tick (12 MHz clock).
REQ-002 Parameter DEB_CYCLES, default 120000, meaning: consecutive stable samples needed to accept a button level (10 ms).
REQ-003 Port CLK  input  1  system clock; all state updates on rising edge.
REQ-004 Port RESET  input  1  reset, asynchronous, active-high.
REQ-005 Port BTN_START  input  1  raw start/stop pushbutton; asynchronous; bouncy; active-high.
REQ-006 Port BTN_CLEAR  input  1  raw clear pushbutton; asynchronous; bouncy; active-high.
REQ-007 Port BTN_LAP  input  1  raw lap pushbutton; asynchronous; bouncy; active-high.
REQ-008 Port CNT_EN  output  1  one-cycle 1 Hz advance pulse to the seconds/minutes counter chain.
REQ-009 Port CNT_CLR  output  1  one-cycle synchronous clear pulse to the counter chain.
REQ-010 Port LAP_HOLD  output  1  level; high = display frozen, counting continues.
REQ-011 Port STATE  output  2  current state: 00 IDLE, 01 RUN, 10 PAUSE; 11 never driven.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce: accepted level SHALL change only after DEB_CYCLES consecutive synchronized samples differ from it; any sample equal to the accepted level resets the stability count to 0.
REQ-014 Press event SHALL be a one-cycle pulse on an accepted-level 0->1 transition; releases generate no event.
REQ-015 Prescaler: width ceil(log2(SEC1_MAX)) bits, range 0..SEC1_MAX-1; increments in every cycle whose current state is RUN; wraps to 0 after SEC1_MAX-1.
REQ-016 Prescaler SHALL hold its value in PAUSE (sub-second phase preserved) and be 0 in IDLE.
REQ-017 CNT_EN SHALL be combinationally high iff current state is RUN and prescaler == SEC1_MAX-1; exactly one pulse per SEC1_MAX RUN cycles.
REQ-018 A press event in cycle N SHALL take effect on STATE/LAP_HOLD at the edge ending cycle N.
REQ-019 IDLE: START -> RUN; CLEAR -> stay IDLE, CNT_CLR pulse; LAP ignored.
REQ-020 RUN: START -> PAUSE; LAP toggles LAP_HOLD; CLEAR ignored.
REQ-021 PAUSE: START -> RUN; CLEAR -> IDLE, CNT_CLR pulse, LAP_HOLD to 0, prescaler to 0; LAP sets LAP_HOLD to 0.
REQ-022 Simultaneous events, priority: CLEAR > START > LAP; the lower-priority events in that cycle are discarded (in RUN, CLEAR is ignored, so START wins).
REQ-023 CNT_CLR SHALL be registered and high for exactly the one cycle after the CLEAR event.
REQ-024 A stop event coinciding with prescaler == SEC1_MAX-1 SHALL still produce that CNT_EN pulse; the prescaler wraps to 0 and then holds.
REQ-025 STATE encoding 11 SHALL never occur; if it does, the FSM returns to IDLE on the next edge.

Reset
REQ-026 RESET high SHALL immediately force: STATE=IDLE, prescaler=0, CNT_EN=0, CNT_CLR=0, LAP_HOLD=0, synchronizers=0, accepted levels=0, stability counts=0.
REQ-027 A button held through reset release SHALL be seen as a fresh press after DEB_CYCLES.
REQ-028 Reset mid-RUN SHALL discard any pending CNT_EN; no pulse appears in the first cycle after release.

Verification (SEC1_MAX=10, DEB_CYCLES=4)
REQ-029 START held 10 cycles from IDLE -> STATE=01 exactly 2 sync + 4 debounce cycles (+1 edge) after press; CNT_EN every 10th cycle thereafter.
REQ-030 START bouncing 1,0,1,0 at 1-cycle spacing, then stable high -> exactly one press event; a single RUN transition.
REQ-031 RUN, stop when prescaler=6, resume after 50 cycles -> first CNT_EN 3 RUN cycles after resume.
REQ-032 PAUSE with START and CLEAR same cycle -> STATE=IDLE, CNT_CLR one pulse, LAP_HOLD=0, no RUN.
REQ-033 RUN, LAP press twice -> LAP_HOLD 0->1->0; CNT_EN cadence unchanged throughout.
REQ-034 RESET asserted asynchronously mid-RUN at prescaler=9 -> all outputs 0 before next CLK edge; STATE=00.
